// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for the mem_resp memory responder.
//   state_t  - responder FSM states (IDLE / BUSY / DONE)
//   LAT_W    - width of the latency down-counter
//   LAT_MIN/LAT_MAX, lat_ok() - legal range for the RD_LAT / WR_LAT parameters
package mem_resp_pkg;

    localparam int unsigned LAT_W   = 4;
    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit lat_ok(input int unsigned lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: 2^ADDR_W x 32-bit word storage.
//   clk   - write clock (rising edge)
//   we    - write enable; wdata is stored at waddr on the rising edge
//   waddr - word write address
//   wdata - write data
//   raddr - word read address (asynchronous read)
//   rdata - read data for raddr
// Contents have no reset.
module mem_array #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_resp.sv
// mem_resp: word-organised main-memory responder for the cache strobe/ready bus.
//   clk      - clock, rising edge
//   clrn     - asynchronous active-low reset
//   m_a      - byte address; word index is m_a[ADDR_W+1:2]
//   m_din    - write data
//   m_strobe - request valid, held until m_ready
//   m_rw     - 1 = write, 0 = read
//   m_dout   - read data, valid while m_ready = 1, held until the next read completes
//   m_ready  - registered one-cycle completion pulse
//   rd_cnt   - completed reads (wraps)
//   wr_cnt   - completed writes (wraps)
// A request is accepted in IDLE, waits RD_LAT / WR_LAT cycles, and completes in DONE.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 3,
    parameter int unsigned WR_LAT = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] m_a,
    input  logic [31:0] m_din,
    input  logic        m_strobe,
    input  logic        m_rw,
    output logic [31:0] m_dout,
    output logic        m_ready,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    if (!lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("mem_resp: RD_LAT out of range 1..15");
    end
    if (!lat_ok(WR_LAT)) begin : g_bad_wr_lat
        $error("mem_resp: WR_LAT out of range 1..15");
    end

    localparam logic [LAT_W-1:0] RD_LOAD = LAT_W'(RD_LAT - 1);
    localparam logic [LAT_W-1:0] WR_LOAD = LAT_W'(WR_LAT - 1);

    state_t             state, state_nxt;
    logic [LAT_W-1:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0]  idx_q;
    logic               rw_q;
    logic [31:0]        din_q;

    logic [ADDR_W-1:0]  req_idx;
    logic [ADDR_W-1:0]  rd_idx;
    logic               eff_rw;
    logic               accept;
    logic               arr_we;
    logic [31:0]        arr_rdata;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m_a[31:ADDR_W+2], m_a[1:0]};

    assign req_idx = m_a[ADDR_W+1:2];
    assign accept  = (state == IDLE) && m_strobe;

    // With a latency of 1 the request enters DONE straight from IDLE, before the
    // latches are loaded, so the read address and direction come from the bus then.
    assign rd_idx  = (state == IDLE) ? req_idx : idx_q;
    assign eff_rw  = (state == IDLE) ? m_rw    : rw_q;

    // Write commits at the edge ending DONE; an async reset drops state out of
    // DONE first, so a reset request never reaches the array.
    assign arr_we  = (state == DONE) && rw_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (m_strobe) begin
                    cnt_nxt   = m_rw ? WR_LOAD : RD_LOAD;
                    state_nxt = (cnt_nxt == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt_nxt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            rw_q    <= 1'b0;
            din_q   <= '0;
            m_ready <= 1'b0;
            m_dout  <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            m_ready <= (state_nxt == DONE);
            if (accept) begin
                idx_q <= req_idx;
                rw_q  <= m_rw;
                din_q <= m_din;
            end
            if ((state_nxt == DONE) && (state != DONE) && !eff_rw) begin
                m_dout <= arr_rdata;
            end
            if (state == DONE) begin
                if (rw_q) begin
                    wr_cnt <= wr_cnt + 32'd1;
                end else begin
                    rd_cnt <= rd_cnt + 32'd1;
                end
            end
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (idx_q),
        .wdata (din_q),
        .raddr (rd_idx),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: self-checking bench for mem_resp.
// Two instances: default latencies (dut0) and RD_LAT=WR_LAT=1 (dut1).
// Expectations come from a word-array model indexed by (addr / 4) mod 1024.
module tb_mem_resp;

    logic        clk;
    logic        clrn;
    logic [31:0] m_a;
    logic [31:0] m_din;
    logic        m_rw;
    logic        stb0, stb1;
    logic [31:0] dout0, dout1;
    logic        rdy0, rdy1;
    logic [31:0] rc0, wc0, rc1, wc1;

    int unsigned total;
    int unsigned bad;

    logic [31:0] mdl_mem  [2][1024];
    bit          mdl_ok   [2][1024];
    logic [31:0] mdl_dout [2];
    int unsigned mdl_rd   [2];
    int unsigned mdl_wr   [2];

    mem_resp #(
        .ADDR_W (10),
        .RD_LAT (3),
        .WR_LAT (2)
    ) dut (
        .clk      (clk),
        .clrn     (clrn),
        .m_a      (m_a),
        .m_din    (m_din),
        .m_strobe (stb0),
        .m_rw     (m_rw),
        .m_dout   (dout0),
        .m_ready  (rdy0),
        .rd_cnt   (rc0),
        .wr_cnt   (wc0)
    );

    mem_resp #(
        .ADDR_W (10),
        .RD_LAT (1),
        .WR_LAT (1)
    ) dut1 (
        .clk      (clk),
        .clrn     (clrn),
        .m_a      (m_a),
        .m_din    (m_din),
        .m_strobe (stb1),
        .m_rw     (m_rw),
        .m_dout   (dout1),
        .m_ready  (rdy1),
        .rd_cnt   (rc1),
        .wr_cnt   (wc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned lat_of(input int s, input logic rw);
        if (s == 1) return 1;
        return rw ? 2 : 3;
    endfunction

    // Issue one request on DUT s and check its completion.
    // hold: leave strobe high afterwards (caller issues the next request at once).
    // drop: release strobe right after the accept edge.
    task automatic do_req(input int s, input logic rw, input logic [31:0] a,
                          input logic [31:0] d, input bit hold, input bit drop);
        int unsigned idx;
        int unsigned k;
        idx   = (a >> 2) % 1024;
        k     = 0;
        m_a   = a;
        m_din = d;
        m_rw  = rw;
        if (s == 0) stb0 = 1'b1; else stb1 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                // Bus fields after accept must be ignored.
                m_a   = $urandom;
                m_din = $urandom;
                m_rw  = 1'($urandom);
                if (drop) begin
                    if (s == 0) stb0 = 1'b0; else stb1 = 1'b0;
                end
            end
            if ((s == 0) ? rdy0 : rdy1) begin
                k = i;
                break;
            end
        end
        chk("ready_latency", k, lat_of(s, rw));
        if (!hold) begin
            if (s == 0) stb0 = 1'b0; else stb1 = 1'b0;
        end
        if (rw) begin
            mdl_mem[s][idx] = d;
            mdl_ok[s][idx]  = 1'b1;
            mdl_wr[s]++;
        end else begin
            mdl_dout[s] = mdl_mem[s][idx];
            mdl_rd[s]++;
        end
        chk("dout", (s == 0) ? dout0 : dout1, mdl_dout[s]);
        @(posedge clk);
        #1;
        chk("ready_pulse_end", {31'd0, (s == 0) ? rdy0 : rdy1}, 32'd0);
        chk("rd_cnt", (s == 0) ? rc0 : rc1, mdl_rd[s]);
        chk("wr_cnt", (s == 0) ? wc0 : wc1, mdl_wr[s]);
    endtask

    initial begin
        logic [31:0] ra;
        logic        rrw;
        int unsigned ri;
        bit          hold;
        total = 0;
        bad   = 0;
        for (int s = 0; s < 2; s++) begin
            mdl_dout[s] = '0;
            mdl_rd[s]   = 0;
            mdl_wr[s]   = 0;
            for (int j = 0; j < 1024; j++) mdl_ok[s][j] = 1'b0;
        end
        clrn  = 1'b0;
        stb0  = 1'b0;
        stb1  = 1'b0;
        m_a   = '0;
        m_din = '0;
        m_rw  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ready", {31'd0, rdy0}, 32'd0);
        chk("reset_dout", dout0, 32'd0);
        chk("reset_rd_cnt", rc0, 32'd0);
        chk("reset_wr_cnt", wc0, 32'd0);
        chk("reset_ready1", {31'd0, rdy1}, 32'd0);
        clrn = 1'b1;
        @(negedge clk);

        // Preload word 5, then read it back.
        do_req(0, 1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 0, 0);
        do_req(0, 1'b0, 32'h0000_0014, 32'h0, 0, 0);
        // Write then immediate read of the same word.
        do_req(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 0, 0);
        do_req(0, 1'b0, 32'h0000_0020, 32'h0, 0, 0);
        // Aliased address returns word 5.
        do_req(0, 1'b0, 32'h0000_1014, 32'h0, 0, 0);
        // Back-to-back with strobe held.
        do_req(0, 1'b1, 32'h0000_0040, 32'hCAFE_0001, 1, 0);
        do_req(0, 1'b0, 32'h0000_0020, 32'h0, 1, 0);
        do_req(0, 1'b0, 32'hFFFF_F043, 32'h0, 1, 0);
        do_req(0, 1'b1, 32'h0000_0044, 32'hCAFE_0002, 0, 0);
        // Latency-1 instance.
        do_req(1, 1'b1, 32'h0000_0008, 32'h0BAD_F00D, 0, 0);
        do_req(1, 1'b0, 32'h0000_0008, 32'h0, 0, 0);
        // Strobe dropped in BUSY still completes.
        do_req(0, 1'b1, 32'h0000_0030, 32'hAAAA_5555, 0, 1);
        do_req(0, 1'b0, 32'h0000_0030, 32'h0, 0, 0);

        // Reset while a write to word 5 is in BUSY.
        @(negedge clk);
        m_a   = 32'h0000_0014;
        m_din = 32'h1111_1111;
        m_rw  = 1'b1;
        stb0  = 1'b1;
        @(posedge clk);
        #1;
        clrn = 1'b0;
        stb0 = 1'b0;
        #1;
        chk("rst_busy_ready", {31'd0, rdy0}, 32'd0);
        chk("rst_busy_rd_cnt", rc0, 32'd0);
        chk("rst_busy_wr_cnt", wc0, 32'd0);
        chk("rst_busy_dout", dout0, 32'd0);
        for (int s = 0; s < 2; s++) begin
            mdl_dout[s] = '0;
            mdl_rd[s]   = 0;
            mdl_wr[s]   = 0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy_ready_held", {31'd0, rdy0}, 32'd0);
        clrn = 1'b1;
        @(negedge clk);
        do_req(0, 1'b0, 32'h0000_0014, 32'h0, 0, 0);

        // Read counter wrap.
        @(negedge clk);
        force dut.rd_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.rd_cnt;
        mdl_rd[0] = 32'hFFFF_FFFF;
        @(negedge clk);
        do_req(0, 1'b0, 32'h0000_0020, 32'h0, 0, 0);

        // Randomised traffic on both instances.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 30; n++) begin
                ri  = $urandom_range(0, 15);
                ra  = ($urandom & 32'hFFFF_F003) | (ri << 2);
                rrw = 1'($urandom);
                if (!mdl_ok[s][ri]) rrw = 1'b1;
                hold = (n < 29) && ($urandom_range(0, 1) == 1);
                do_req(s, rrw, ra, $urandom, hold, 0);
                if (!hold && ($urandom_range(0, 2) == 0)) @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
